// File: rtl/fp_align_sign_pipe_pkg.sv
// Shared widths and record types for the floating-point adder datapath.
package fp_add_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 24;
  localparam int FP_GRS_W = 3;
  localparam int FP_W     = FP_MAN_W + FP_GRS_W;
  localparam int FP_OW    = FP_W + 2;

  // Unpacked operand as delivered by the unpacker (hidden bit explicit).
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] mant;
  } operand_t;

  // Aligned operand pair handed to the mantissa adder.
  typedef struct packed {
    logic [FP_OW-1:0]    op_l;
    logic [FP_OW-1:0]    op_s;
    logic [FP_EXP_W-1:0] exp;
    logic                sign;
    logic                eff_sub;
  } aligned_t;

endpackage

// File: rtl/fp_align_sign_pipe_if.sv
// Operand-in / aligned-pair-out handshake bundle for the alignment stage.
interface fp_align_sign_pipe_if
  import fp_add_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int GRS_W = FP_GRS_W
);
  localparam int OW = MAN_W + GRS_W + 2;

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             sign_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] mant_a;
  logic [MAN_W-1:0] mant_b;

  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    op_l;
  logic [OW-1:0]    op_s;
  logic [EXP_W-1:0] exp_out;
  logic             sign_out;
  logic             eff_sub;

  // Producer/consumer side: drives operands and downstream ready.
  modport master (
    output in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, op_l, op_s, exp_out, sign_out, eff_sub
  );

  // Alignment stage side.
  modport slave (
    input  in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, op_l, op_s, exp_out, sign_out, eff_sub
  );

endinterface

// File: rtl/fp_align_sign_pipe_sticky_shifter.sv
// Combinational right shifter: bits shifted out are ORed into the LSB
// (sticky); shifts of W or more collapse to a lone sticky bit.
module fp_sticky_shifter #(
  parameter int W     = 27,
  parameter int EXP_W = 8
) (
  input  logic [W-1:0]     ext,
  input  logic [EXP_W-1:0] diff,
  output logic [W-1:0]     aligned
);

  logic [31:0]  diff32;
  logic [W-1:0] lost_mask;
  logic [W-1:0] shifted;
  logic         sticky;
  logic         saturate;

  assign diff32 = 32'(diff);

  // Bit gi of ext falls off the bottom when it sits below the shift amount.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_mask
      assign lost_mask[gi] = (32'(gi) < diff32);
    end
  endgenerate

  assign saturate = (diff32 >= 32'(W));
  assign shifted  = ext >> diff;
  assign sticky   = |(ext & lost_mask);

  // Shifted value with sticky folded into the LSB, or saturated result.
  always_comb begin
    aligned = shifted | W'(sticky);
    if (saturate) begin
      aligned = {{(W-1){1'b0}}, |ext};
    end
  end

endmodule

// File: rtl/fp_align_sign_pipe.sv
// Two-stage alignment / sign-conversion stage ahead of the mantissa adder.
// Stage 1 orders operands by magnitude; stage 2 aligns the smaller one and
// negates it for effective subtraction so the adder sum is never negative.
module fp_align_sign_pipe
  import fp_add_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int GRS_W = FP_GRS_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_align_sign_pipe_if.slave bus
);

  localparam int W  = MAN_W + GRS_W;
  localparam int OW = W + 2;

  // Handshake
  logic s2_adv;
  logic in_ready_int;
  logic accept;

  // Stage 1 ordering
  logic             sb;
  logic             a_less_b;
  logic [MAN_W-1:0] mant_l_next, mant_s_next;
  logic [EXP_W-1:0] exp_l_next, exp_s_next;
  logic             sign_l_next;

  logic             s1_valid_reg;
  logic [MAN_W-1:0] mant_l_reg, mant_s_reg;
  logic [EXP_W-1:0] exp_l_reg, diff_reg;
  logic             sign_l_reg, eff_sub_s1_reg;

  // Stage 2 alignment
  logic [W-1:0]     ext_s, aligned;
  logic [OW-1:0]    aligned_z, op_l_next, op_s_next;

  logic             out_valid_reg;
  logic [OW-1:0]    op_l_reg, op_s_reg;
  logic [EXP_W-1:0] exp_out_reg;
  logic             sign_out_reg, eff_sub_reg;

  assign s2_adv       = !out_valid_reg || bus.out_ready;
  assign in_ready_int = !s1_valid_reg || s2_adv;
  assign accept       = bus.in_valid && in_ready_int;

  // Equal magnitudes keep a as the larger operand.
  assign sb          = bus.sign_b ^ bus.op_sub;
  assign a_less_b    = (bus.exp_a < bus.exp_b) ||
                       ((bus.exp_a == bus.exp_b) && (bus.mant_a < bus.mant_b));
  assign mant_l_next = a_less_b ? bus.mant_b : bus.mant_a;
  assign mant_s_next = a_less_b ? bus.mant_a : bus.mant_b;
  assign exp_l_next  = a_less_b ? bus.exp_b  : bus.exp_a;
  assign exp_s_next  = a_less_b ? bus.exp_a  : bus.exp_b;
  assign sign_l_next = a_less_b ? sb         : bus.sign_a;

  // Stage 1 register: capture the ordered pair on accept, drain when s2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      mant_l_reg     <= '0;
      mant_s_reg     <= '0;
      exp_l_reg      <= '0;
      diff_reg       <= '0;
      sign_l_reg     <= 1'b0;
      eff_sub_s1_reg <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_reg   <= 1'b1;
        mant_l_reg     <= mant_l_next;
        mant_s_reg     <= mant_s_next;
        exp_l_reg      <= exp_l_next;
        diff_reg       <= exp_l_next - exp_s_next;
        sign_l_reg     <= sign_l_next;
        eff_sub_s1_reg <= bus.sign_a ^ sb;
      end else if (s2_adv) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign ext_s = {mant_s_reg, {GRS_W{1'b0}}};

  fp_sticky_shifter #(
    .W     (W),
    .EXP_W (EXP_W)
  ) u_shifter (
    .ext     (ext_s),
    .diff    (diff_reg),
    .aligned (aligned)
  );

  assign aligned_z = {2'b00, aligned};
  assign op_s_next = eff_sub_s1_reg ? (~aligned_z + OW'(1)) : aligned_z;
  assign op_l_next = {2'b00, mant_l_reg, {GRS_W{1'b0}}};

  // Stage 2 register: load from s1 whenever the output slot is free or consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      op_l_reg      <= '0;
      op_s_reg      <= '0;
      exp_out_reg   <= '0;
      sign_out_reg  <= 1'b0;
      eff_sub_reg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        op_l_reg     <= op_l_next;
        op_s_reg     <= op_s_next;
        exp_out_reg  <= exp_l_reg;
        sign_out_reg <= sign_l_reg;
        eff_sub_reg  <= eff_sub_s1_reg;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.op_l      = op_l_reg;
  assign bus.op_s      = op_s_reg;
  assign bus.exp_out   = exp_out_reg;
  assign bus.sign_out  = sign_out_reg;
  assign bus.eff_sub   = eff_sub_reg;

endmodule

// File: doc/fp_align_sign_pipe.md
Name: fp_align_sign_pipe

Overview:
- Parametrised, pipelined alignment and sign-conversion stage for the floating-point adder datapath.
- Inputs: two unpacked operands (sign, biased exponent, mantissa with hidden bit).
- Orders the operands by magnitude, right-shifts the smaller mantissa with guard/round/sticky extension, and converts it to two's complement when the effective operation is a subtract. The downstream adder then always produces a non-negative sum.
- Sits between the unpacker and the mantissa adder; valid/ready on both sides.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 24, mantissa width including hidden bit
- GRS_W, 3, extension bits below the mantissa LSB; the lowest is sticky (must be >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand pair valid
- in_ready  out  1  block can accept the pair this cycle
- op_sub  in  1  1 = compute a-b (inverts sign_b internally)
- sign_a, sign_b  in  1 each  operand signs
- exp_a, exp_b  in  EXP_W each  biased exponents
- mant_a, mant_b  in  MAN_W each  magnitudes, hidden bit explicit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts this cycle
- op_l  out  MAN_W+GRS_W+2  larger magnitude, zero-extended, always positive
- op_s  out  MAN_W+GRS_W+2  aligned smaller magnitude; two's complement when eff_sub=1
- exp_out  out  EXP_W  exponent of the larger operand
- sign_out  out  1  result sign (sign of the larger operand)
- eff_sub  out  1  effective subtraction (signs differ after op_sub)

Behaviour:
- Let W = MAN_W+GRS_W and OW = W+2.
- Reset (async assert, sync deassert is the integrator's job):
  - s1_valid, s2_valid (out_valid) = 0.
  - All data registers = 0, so op_l, op_s, exp_out, sign_out, eff_sub = 0.
  - in_ready = 1 once reset is released.
- Stage 1 (capture on in_valid && in_ready):
  - sb = sign_b ^ op_sub.
  - a_less_b = (exp_a<exp_b) || (exp_a==exp_b && mant_a<mant_b). Ties (equal magnitude) choose a as larger.
  - Register: L/S mantissas, exp_l, diff = exp_l-exp_s (unsigned, EXP_W bits), sign_l, eff_sub = sign_a ^ sb.
- Stage 2:
  - ext = {mant_s, GRS_W zeros} (W bits).
  - If diff >= W: aligned = 0 with LSB = |mant_s.
  - Otherwise: aligned = ext >> diff, with LSB ORed with the OR of all bits shifted out.
  - op_l = zero-extended {mant_l, GRS_W zeros}.
  - op_s = eff_sub ? (~zext(aligned)+1) mod 2^OW : zext(aligned).
  - aligned == 0 with eff_sub gives op_s = 0.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Throughput: 1 per cycle.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 under that same condition.
  - in_ready = !s1_valid || (s2 advances). Combinational from out_ready; no combinational path from in_valid.
- Stall rules:
  - While out_valid && !out_ready, all outputs hold stable.
  - Order is preserved and no transaction is dropped or duplicated.
  - Simultaneous out-consume and in-accept with both stages full is legal: full throughput is kept.
- Input data is ignored when in_valid=0. Exponent/mantissa special values (zero, inf, NaN) are passed as plain numbers; the unpacker handles them.
- Reset mid-operation: in-flight transactions are discarded and out_valid drops immediately.

Decomposition:
- Package fp_add_pkg:
  - localparams EXP_W, MAN_W, GRS_W defaults.
  - typedef for the unpacked operand struct {sign, exp, mant}.
  - typedef for the aligned-pair struct {op_l, op_s, exp, sign, eff_sub}.
- One sub-module, fp_sticky_shifter: combinational right shift with sticky OR and saturation at diff>=W, parametrised on W and EXP_W.

Test Plan:
All cases use defaults: W=27, OW=29.
- a=+1.0 (exp 127, mant 0x800000), b=+1.0, op_sub=0 -> 2 cycles later: op_l=0x4000000, op_s=0x4000000, exp_out=127, sign_out=0, eff_sub=0.
- a=+1.0, b=+0.5 (exp 126, mant 0x800000), op_sub=1 -> op_l=0x4000000, op_s=0x1E000000, sign_out=0, eff_sub=1.
- exp_a=127 mant_a=0x800000, exp_b=90 mant_b=0x800001, same sign -> diff=37>=27, op_s=0x0000001 (sticky only), exp_out=127.
- exp 130 both, a=+0xC00000, b=-0xE00000 -> b larger: op_l=0x7000000, op_s=0x1A000000, sign_out=1, eff_sub=1.
- out_ready=0 for 5 cycles while offering 3 pairs back-to-back:
  - 2 are accepted, then in_ready=0.
  - Outputs are frozen.
  - After release, all 3 emerge in order, one per cycle.
- Both stages valid, rst_n pulsed low mid-cycle -> out_valid=0 and all outputs=0 asynchronously; after release in_ready=1 and no stale result appears.
